// File: rtl/iir_cascade_ctrl.sv
// Coefficient shadow/active bank, commit sequencer and sample-valid gating for the biquad cascade.
// Latency: shadow write 1 edge; commit swaps on the first engine-idle edge (or at the commit edge when flushing).
// Backpressure: none upstream; samples arriving while the engine is busy are forwarded and flagged, samples during a flush are dropped.
module iir_cascade_ctrl #(
  parameter int CASCADE_LEVEL = 10,
  parameter int CWIDTH        = 24,
  parameter int AWIDTH        = 6,
  parameter int TIMEOUT       = 1023
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              ctrl_en,
  input  logic                              cfg_wr,
  input  logic [AWIDTH-1:0]                 cfg_addr,
  input  logic [CWIDTH-1:0]                 cfg_wdata,
  input  logic                              cfg_commit,
  input  logic                              cfg_flush,
  input  logic                              src_vld,
  output logic                              din_vld,
  output logic                              block_en,
  output logic [CASCADE_LEVEL*CWIDTH*5-1:0] coefs,
  output logic [CWIDTH-1:0]                 scale,
  output logic                              commit_busy,
  output logic                              commit_done,
  output logic                              cfg_err,
  output logic                              overrun,
  output logic                              sample_drop
);

  localparam int NCOEF = 5 * CASCADE_LEVEL;
  localparam int NREG  = NCOEF + 1;
  localparam int BW    = $clog2(CASCADE_LEVEL + 2);
  localparam int WW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GAP = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [WW-1:0]                   wait_q, wait_d;
  logic                            fcnt_q, fcnt_d;
  logic [BW-1:0]                   busy_q;
  logic [NREG-1:0][CWIDTH-1:0]     shadow_q, shadow_d;
  logic [NREG-1:0][CWIDTH-1:0]     active_q;
  logic                            block_en_q;
  logic                            done_q, done_d;
  logic                            err_q, err_d;
  logic                            ovr_q;
  logic                            drop_q;
  logic                            swap;
  logic                            wr_ok;
  logic                            flushing;
  logic                            engine_idle;

  // Word index equals config address, so the coefficient bank maps straight onto the packed output.
  assign coefs       = active_q[NCOEF-1:0];
  assign scale       = active_q[NCOEF];
  assign flushing    = (state_q == FLUSH);
  assign din_vld     = src_vld & block_en_q & ~flushing;
  // Idle is judged on the gated strobe so a disabled path never stalls a commit.
  assign engine_idle = (busy_q == '0) & ~din_vld;
  assign wr_ok       = cfg_wr & (state_q == IDLE) & (cfg_addr <= AWIDTH'(NCOEF));
  assign block_en    = block_en_q;
  assign commit_busy = (state_q != IDLE);
  assign commit_done = done_q;
  assign cfg_err     = err_q;
  assign overrun     = ovr_q;
  assign sample_drop = drop_q;

  // Shadow next value: an accepted write lands here so a same-cycle commit picks it up.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NREG; i++) begin
      if (wr_ok && (cfg_addr == AWIDTH'(i))) begin
        shadow_d[i] = cfg_wdata;
      end
    end
  end

  // Commit sequencer: next state, swap strobe, wait/flush counters and status pulses.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fcnt_d  = fcnt_q;
    swap    = 1'b0;
    done_d  = 1'b0;
    err_d   = cfg_wr & ~wr_ok;
    case (state_q)
      IDLE: begin
        if (cfg_commit) begin
          if (cfg_flush) begin
            state_d = FLUSH;
            swap    = 1'b1;
            fcnt_d  = 1'b0;
          end else begin
            state_d = WAIT_GAP;
            wait_d  = '0;
          end
        end
      end
      WAIT_GAP: begin
        if (cfg_commit) begin
          err_d = 1'b1;
        end
        if (engine_idle) begin
          swap    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      FLUSH: begin
        if (cfg_commit) begin
          err_d = 1'b1;
        end
        // Done is raised from the first flush cycle so it is seen during the second.
        if (!fcnt_q) begin
          done_d = 1'b1;
          fcnt_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered status pulses; reset abandons any commit in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      fcnt_q     <= 1'b0;
      block_en_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      fcnt_q     <= fcnt_d;
      block_en_q <= ctrl_en & (state_d != FLUSH);
      done_q     <= done_d;
      err_q      <= err_d;
      ovr_q      <= src_vld & (busy_q != '0);
      drop_q     <= src_vld & flushing;
    end
  end

  // Engine occupancy: reload on every forwarded sample, count down otherwise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q <= '0;
    end else if (din_vld) begin
      busy_q <= BW'(CASCADE_LEVEL + 1);
    end else if (busy_q != '0) begin
      busy_q <= busy_q - BW'(1);
    end
  end

  // Coefficient banks: shadow follows writes, active takes the whole shadow in one edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (swap) begin
        active_q <= shadow_d;
      end
    end
  end

endmodule

// File: tb/tb_iir_cascade_ctrl.sv
// Bench for iir_cascade_ctrl: directed scenarios followed by random traffic,
// all checked every cycle against a timestamp/transaction-level model.
module tb_iir_cascade_ctrl;
  localparam int CL = 10;
  localparam int CW = 24;
  localparam int AW = 6;
  localparam int TO = 1023;
  localparam int NC = 5 * CL;
  localparam int NR = NC + 1;

  logic                 clk = 1'b0;
  logic                 rstn, ctrl_en, cfg_wr, cfg_commit, cfg_flush, src_vld;
  logic [AW-1:0]        cfg_addr;
  logic [CW-1:0]        cfg_wdata;
  logic                 din_vld, block_en, commit_busy, commit_done, cfg_err, overrun, sample_drop;
  logic [CL*CW*5-1:0]   coefs;
  logic [CW-1:0]        scale;

  iir_cascade_ctrl #(.CASCADE_LEVEL(CL), .CWIDTH(CW), .AWIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .ctrl_en(ctrl_en), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_flush(cfg_flush), .src_vld(src_vld),
    .din_vld(din_vld), .block_en(block_en), .coefs(coefs), .scale(scale),
    .commit_busy(commit_busy), .commit_done(commit_done), .cfg_err(cfg_err),
    .overrun(overrun), .sample_drop(sample_drop)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: banks as arrays, engine occupancy as "time since last sample",
  // commit progress as a pending flag with an age and a flush countdown.
  logic [CW-1:0] m_sh  [NR];
  logic [CW-1:0] m_act [NR];
  bit  m_ben, m_done, m_err, m_ovr, m_drop, m_pend;
  int  m_age, m_fl, m_last, m_cyc;
  bit  chk_on = 1'b0;

  int obs_done, obs_err, obs_drop, obs_ovr, obs_busy, obs_din, obs_ben0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, m_cyc);
    else n_pass++;
  endtask

  function automatic logic [CW-1:0] dut_word(input int i);
    if (i < NC) return coefs[i*CW +: CW];
    return scale;
  endfunction

  task automatic clr_in();
    rstn = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cfg_commit = 1'b0; cfg_flush = 1'b0; src_vld = 1'b0;
  endtask

  task automatic clr_obs();
    obs_done = 0; obs_err = 0; obs_drop = 0; obs_ovr = 0; obs_busy = 0; obs_din = 0; obs_ben0 = 0;
  endtask

  // One clock: compare DUT against model, advance model over the edge, advance time.
  task automatic tick();
    bit flushing, busy, e_din, idle, wok, n_err, n_done;
    int idx;
    #1;
    flushing = (m_fl > 0);
    busy     = (m_cyc - m_last >= 1) && (m_cyc - m_last <= CL + 1);
    e_din    = src_vld && m_ben && !flushing;
    if (chk_on) begin
      chk("din_vld", din_vld, e_din);
      chk("block_en", block_en, m_ben);
      chk("commit_busy", commit_busy, m_pend || flushing);
      chk("commit_done", commit_done, m_done);
      chk("cfg_err", cfg_err, m_err);
      chk("overrun", overrun, m_ovr);
      chk("sample_drop", sample_drop, m_drop);
      idx = 0;
      for (int i = NR - 1; i >= 0; i--) if (dut_word(i) !== m_act[i]) idx = i;
      chk($sformatf("bank[%0d]", idx), dut_word(idx), m_act[idx]);
    end
    obs_done += int'(commit_done); obs_err += int'(cfg_err); obs_drop += int'(sample_drop);
    obs_ovr += int'(overrun); obs_busy += int'(commit_busy); obs_din += int'(din_vld);
    obs_ben0 += int'(!block_en);
    if (!rstn) begin
      for (int i = 0; i < NR; i++) begin m_sh[i] = '0; m_act[i] = '0; end
      m_ben = 0; m_done = 0; m_err = 0; m_ovr = 0; m_drop = 0;
      m_pend = 0; m_age = 0; m_fl = 0; m_last = -1000;
    end else begin
      idle   = !busy && !e_din;
      wok    = cfg_wr && !m_pend && !flushing && (int'(cfg_addr) <= NC);
      n_err  = cfg_wr && !wok;
      n_done = 0;
      if (wok) m_sh[int'(cfg_addr)] = cfg_wdata;
      if (flushing) begin
        if (cfg_commit) n_err = 1;
        if (m_fl == 2) n_done = 1;
        m_fl--;
      end else if (m_pend) begin
        if (cfg_commit) n_err = 1;
        if (idle) begin
          for (int i = 0; i < NR; i++) m_act[i] = m_sh[i];
          n_done = 1; m_pend = 0;
        end else begin
          m_age++;
          if (m_age == TO) begin n_err = 1; m_pend = 0; end
        end
      end else if (cfg_commit) begin
        if (cfg_flush) begin
          for (int i = 0; i < NR; i++) m_act[i] = m_sh[i];
          m_fl = 2;
        end else begin
          m_pend = 1; m_age = 0;
        end
      end
      m_ovr = src_vld && busy; m_drop = src_vld && flushing;
      m_err = n_err; m_done = n_done;
      m_ben = ctrl_en && (m_fl == 0);
      if (e_din) m_last = m_cyc;
    end
    m_cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) begin clr_in(); tick(); end
  endtask

  task automatic wr(input int a, input int d);
    clr_in(); cfg_wr = 1'b1; cfg_addr = AW'(a); cfg_wdata = CW'(d); tick();
  endtask

  initial begin
    m_cyc = 0; m_last = -1000;
    ctrl_en = 1'b1;
    clr_in(); rstn = 1'b0;
    tick();
    chk_on = 1'b1;
    tick(); tick();
    idle_n(2);

    // Basic write + non-flush commit with no traffic.
    wr(0, 24'h200000); wr(NC, 24'h200000);
    clr_obs();
    clr_in(); cfg_commit = 1'b1; tick();
    idle_n(3);
    chk("t1_coef0", coefs[CW-1:0], 24'h200000);
    chk("t1_scale", scale, 24'h200000);
    chk("t1_done_cnt", obs_done, 1);

    // Sample then commit: swap waits for the engine window to drain.
    wr(1, 24'h123456);
    clr_obs();
    clr_in(); src_vld = 1'b1; tick();
    clr_in(); cfg_commit = 1'b1; tick();
    idle_n(14);
    chk("t2_busy_cycles", obs_busy, 11);
    chk("t2_coef1", coefs[CW +: CW], 24'h123456);

    // Back-to-back traffic every 12 cycles starves the commit until timeout.
    wr(2, 24'hABCDEF);
    clr_obs();
    for (int k = 0; k < 1040; k++) begin
      clr_in(); src_vld = (k % 12 == 0); cfg_commit = (k == 1); tick();
    end
    chk("t3_err_cnt", obs_err, 1);
    chk("t3_done_cnt", obs_done, 0);
    chk("t3_coef2", coefs[2*CW +: CW], 24'h0);
    chk("t3_busy_end", commit_busy, 1'b0);

    // Flush commit with samples arriving during the flush.
    idle_n(13);
    clr_obs();
    clr_in(); cfg_commit = 1'b1; cfg_flush = 1'b1; tick();
    clr_in(); src_vld = 1'b1; tick();
    clr_in(); src_vld = 1'b1; tick();
    idle_n(2);
    chk("t4_drop_cnt", obs_drop, 2);
    chk("t4_din_cnt", obs_din, 0);
    chk("t4_ben_low", obs_ben0, 2);
    chk("t4_done_cnt", obs_done, 1);
    chk("t4_coef2", coefs[2*CW +: CW], 24'hABCDEF);

    // Rejected writes: out-of-range address, and a write while a commit waits.
    clr_obs();
    wr(NC + 1, 24'h111111);
    clr_in(); src_vld = 1'b1; tick();
    clr_in(); cfg_commit = 1'b1; tick();
    clr_in(); tick();
    wr(3, 24'h555555);
    idle_n(12);
    clr_in(); cfg_commit = 1'b1; tick();
    idle_n(3);
    chk("t5_err_cnt", obs_err, 2);
    chk("t5_coef3", coefs[3*CW +: CW], 24'h0);

    // Overrun, then reset during a pending commit.
    clr_obs();
    for (int k = 0; k < 8; k++) begin clr_in(); src_vld = (k == 0 || k == 5); tick(); end
    idle_n(12);
    chk("t6_ovr_cnt", obs_ovr, 1);
    wr(4, 24'h777777);
    clr_in(); src_vld = 1'b1; tick();
    clr_in(); cfg_commit = 1'b1; tick();
    idle_n(2);
    clr_in(); rstn = 1'b0; tick();
    idle_n(14);
    chk("t6_coef4", coefs[4*CW +: CW], 24'h0);
    chk("t6_scale", scale, 24'h0);

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      clr_in();
      if ($urandom_range(0, 49) == 0) ctrl_en = ~ctrl_en;
      rstn       = ($urandom_range(0, 599) != 0);
      src_vld    = ($urandom_range(0, 9) == 0);
      cfg_wr     = ($urandom_range(0, 5) == 0);
      cfg_addr   = AW'($urandom_range(0, NC + 5));
      cfg_wdata  = CW'($urandom);
      cfg_commit = ($urandom_range(0, 29) == 0);
      cfg_flush  = ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
